// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor conditioner and the downstream FSM stage.
package sensor_pkg;

  localparam int unsigned W_DEF           = 12;
  localparam int unsigned AVG_LOG2_DEF    = 3;
  localparam int unsigned STALE_TICKS_DEF = 63;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALE = 2'd2
  } state_e;

endpackage

// File: rtl/sample_window.sv
// Boxcar window: circular sample buffer, write pointer, fill count and running sum.
module sample_window #(
  parameter int unsigned W        = 12,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] avg_next,
  output logic         full_next
);

  localparam int unsigned D  = 1 << AVG_LOG2;
  localparam int unsigned SW = W + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  logic [W-1:0]          buf_q [D];
  logic [AVG_LOG2-1:0]   wp_q, wp_d;
  logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [SW-1:0]         sum_q, sum_d, sum_next;
  logic [W-1:0]          old;

  // Running-sum update and next pointer/fill state for the current cycle.
  always_comb begin
    old        = (fill_cnt_q == CW'(D)) ? buf_q[wp_q] : '0;
    sum_next   = sum_q + SW'(din) - SW'(old);
    avg_next   = sum_next[SW-1:AVG_LOG2];
    wp_d       = wp_q;
    fill_cnt_d = fill_cnt_q;
    sum_d      = sum_q;
    if (flush) begin
      wp_d       = '0;
      fill_cnt_d = '0;
      sum_d      = '0;
    end else if (push) begin
      sum_d = sum_next;
      wp_d  = wp_q + AVG_LOG2'(1);
      if (fill_cnt_q != CW'(D)) fill_cnt_d = fill_cnt_q + CW'(1);
    end
    full_next = (fill_cnt_d == CW'(D));
  end

  // Pointer, fill count and sum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      fill_cnt_q <= '0;
      sum_q      <= '0;
    end else begin
      wp_q       <= wp_d;
      fill_cnt_q <= fill_cnt_d;
      sum_q      <= sum_d;
    end
  end

  // Sample storage; contents are don't-care until the fill count covers them.
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) buf_q[wp_q] <= din;
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: moving average, baseline capture and stale-stream detection.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned AVG_LOG2    = AVG_LOG2_DEF,
  parameter int unsigned STALE_TICKS = STALE_TICKS_DEF
) (
  input  logic         clk_16ms,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] sample_in,
  input  logic         cal_req,
  output logic [W-1:0] sen,
  output logic [W-1:0] sen_ref,
  output logic         ref_valid,
  output logic         enable_out,
  output logic         stale
);

  localparam int unsigned SCW = $clog2(STALE_TICKS + 1);

  state_e         state_q, state_d;
  logic [SCW-1:0] stale_cnt_q, stale_cnt_d, stale_cnt_inc;
  logic [W-1:0]   sen_q, sen_d, sen_ref_q, sen_ref_d;
  logic           ref_valid_q, ref_valid_d;
  logic           enable_q, enable_d;
  logic           stale_q, stale_d;
  logic           push;
  logic [W-1:0]   avg_next;
  logic           full_next;

  // A calibration request drops any coincident sample.
  assign push = sample_valid & ~cal_req;

  sample_window #(
    .W        (W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk       (clk_16ms),
    .rst       (rst),
    .push      (push),
    .flush     (cal_req),
    .din       (sample_in),
    .avg_next  (avg_next),
    .full_next (full_next)
  );

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    stale_cnt_d   = stale_cnt_q;
    sen_d         = sen_q;
    sen_ref_d     = sen_ref_q;
    ref_valid_d   = ref_valid_q;
    stale_d       = stale_q;
    stale_cnt_inc = stale_cnt_q + SCW'(1);
    if (cal_req) begin
      state_d     = ST_FILL;
      ref_valid_d = 1'b0;
      stale_d     = 1'b0;
      stale_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (sample_valid && full_next) begin
            sen_d       = avg_next;
            sen_ref_d   = avg_next;
            ref_valid_d = 1'b1;
            stale_cnt_d = '0;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (sample_valid) begin
            sen_d       = avg_next;
            stale_cnt_d = '0;
          end else begin
            stale_cnt_d = stale_cnt_inc;
            if (stale_cnt_inc == SCW'(STALE_TICKS)) begin
              stale_d = 1'b1;
              state_d = ST_STALE;
            end
          end
        end
        ST_STALE: begin
          if (sample_valid) begin
            sen_d       = avg_next;
            stale_d     = 1'b0;
            stale_cnt_d = '0;
            state_d     = ST_RUN;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
    enable_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk_16ms) begin
    if (rst) begin
      state_q     <= ST_FILL;
      stale_cnt_q <= '0;
      sen_q       <= '0;
      sen_ref_q   <= '0;
      ref_valid_q <= 1'b0;
      enable_q    <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stale_cnt_q <= stale_cnt_d;
      sen_q       <= sen_d;
      sen_ref_q   <= sen_ref_d;
      ref_valid_q <= ref_valid_d;
      enable_q    <= enable_d;
      stale_q     <= stale_d;
    end
  end

  assign sen        = sen_q;
  assign sen_ref    = sen_ref_q;
  assign ref_valid  = ref_valid_q;
  assign enable_out = enable_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner against a queue-based reference model.
module tb_sensor_conditioner;

  localparam int W     = 12;
  localparam int D     = 8;
  localparam int STALE = 63;

  logic         clk_16ms = 1'b0;
  logic         rst = 1'b1;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic         cal_req = 1'b0;
  logic [W-1:0] sen, sen_ref;
  logic         ref_valid, enable_out, stale;

  sensor_conditioner #(
    .W           (W),
    .AVG_LOG2    (3),
    .STALE_TICKS (STALE)
  ) dut (
    .clk_16ms     (clk_16ms),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .cal_req      (cal_req),
    .sen          (sen),
    .sen_ref      (sen_ref),
    .ref_valid    (ref_valid),
    .enable_out   (enable_out),
    .stale        (stale)
  );

  always #5 clk_16ms = ~clk_16ms;

  typedef struct {
    int sen;
    int sref;
    int rv;
    int en;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: mode 0 = filling, 1 = running, 2 = stalled.
  int   win[$];
  int   mode = 0;
  int   idle = 0;
  exp_t m = '{0, 0, 0, 0, 0};

  function automatic int win_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / D;
  endfunction

  function automatic void model_step(bit sv, int si, bit cal, bit r);
    if (r) begin
      win.delete();
      mode = 0; idle = 0;
      m = '{0, 0, 0, 0, 0};
    end else if (cal) begin
      win.delete();
      mode = 0; idle = 0;
      m.rv = 0; m.st = 0; m.en = 0;
    end else if (sv) begin
      win.push_back(si);
      if (win.size() > D) void'(win.pop_front());
      idle = 0;
      if (mode == 0) begin
        if (win.size() == D) begin
          m.sen = win_avg(); m.sref = win_avg(); m.rv = 1; m.en = 1; mode = 1;
        end
      end else begin
        m.sen = win_avg(); m.st = 0; m.en = 1; mode = 1;
      end
    end else if (mode == 1) begin
      idle++;
      if (idle == STALE) begin
        mode = 2; m.st = 1; m.en = 0;
      end
    end
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge outputs.
  task automatic step(bit sv, int si, bit cal, bit r);
    sample_valid = sv;
    sample_in    = W'(si);
    cal_req      = cal;
    rst          = r;
    model_step(sv, si, cal, r);
    exp_q.push_back(m);
    @(posedge clk_16ms);
    #1;
  endtask

  task automatic direct(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    cmp(name, act, expv);
  endtask

  // Monitor: every edge presents a new output set; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_16ms);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        cmp("sen",        32'(sen),        32'(e.sen));
        cmp("sen_ref",    32'(sen_ref),    32'(e.sref));
        cmp("ref_valid",  32'(ref_valid),  32'(e.rv));
        cmp("enable_out", 32'(enable_out), 32'(e.en));
        cmp("stale",      32'(stale),      32'(e.st));
      end
    end
  end

  initial begin
    int steps2[8] = '{112, 125, 137, 150, 162, 175, 187, 200};
    int held;
    int guard;
    int blk;
    int pct;

    // Test 1: reset then 8 samples of 100, 3 cycles apart.
    step(0, 0, 0, 1);
    direct("reset_sen", 32'(sen), 0);
    direct("reset_en", 32'(enable_out), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 100, 0, 0);
      if (i < 7) direct("t1_rv_low", 32'(ref_valid), 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    direct("t1_sen", 32'(sen), 100);
    direct("t1_en", 32'(enable_out), 1);

    // Test 2: step to 200, one accept every other cycle.
    for (int i = 0; i < 8; i++) begin
      step(1, 200, 0, 0);
      direct("t2_sen", 32'(sen), 32'(steps2[i]));
      direct("t2_ref", 32'(sen_ref), 100);
      step(0, 0, 0, 0);
    end

    // Test 3: full-scale samples, then a single zero.
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 4095, 0, 0);
    direct("t3_sen_max", 32'(sen), 4095);
    direct("t3_ref_max", 32'(sen_ref), 4095);
    step(1, 0, 0, 0);
    direct("t3_sen_drop", 32'(sen), 3583);

    // Test 4: stream stall and recovery.
    for (int i = 0; i < STALE; i++) begin
      step(0, 0, 0, 0);
      if (i == STALE - 2) direct("t4_not_yet", 32'(stale), 0);
    end
    direct("t4_stale", 32'(stale), 1);
    direct("t4_en_off", 32'(enable_out), 0);
    direct("t4_sen_held", 32'(sen), 3583);
    step(1, 100, 0, 0);
    direct("t4_recover", 32'(stale), 0);
    direct("t4_en_on", 32'(enable_out), 1);

    // Test 5: calibration collides with a sample.
    held = int'(sen);
    step(1, 999, 1, 0);
    direct("t5_rv", 32'(ref_valid), 0);
    direct("t5_en", 32'(enable_out), 0);
    direct("t5_sen", 32'(sen), 32'(held));
    for (int i = 0; i < 8; i++) step(1, 50, 0, 0);
    direct("t5_ref", 32'(sen_ref), 50);
    direct("t5_rv1", 32'(ref_valid), 1);

    // Test 6: reset mid-fill restarts the count.
    step(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 77, 0, 0);
    step(1, 77, 0, 1);
    direct("t6_sen0", 32'(sen), 0);
    direct("t6_ref0", 32'(sen_ref), 0);
    for (int i = 0; i < 7; i++) step(1, 77, 0, 0);
    direct("t6_rv7", 32'(ref_valid), 0);
    step(1, 77, 0, 0);
    direct("t6_rv8", 32'(ref_valid), 1);

    // Randomised traffic in blocks of varying sample density.
    for (int b = 0; b < 40; b++) begin
      blk = $urandom_range(0, 3);
      pct = (blk == 0) ? 90 : (blk == 1) ? 30 : (blk == 2) ? 5 : 0;
      for (int c = 0; c < 80; c++) begin
        step(($urandom_range(0, 99) < pct), $urandom_range(0, 4095),
             ($urandom_range(0, 199) == 0), ($urandom_range(0, 599) == 0));
      end
    end

    step(0, 0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk_16ms);
      #4;
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Upstream stage of the per-channel relay-protection FSM. It takes raw sensor samples and smooths them with a boxcar moving average. It captures a baseline reference after each calibration and presents sen, sen_ref and enable to the FSM. It also withholds enable while the reference is not yet valid or while the sensor stream has gone stale.

Parameters:
W, 12, sample/output width in bits
AVG_LOG2, 3, log2 of averaging window depth D (D = 8)
STALE_TICKS, 63, consecutive sample-less cycles in RUN before declaring stale (~1 s at 16 ms)

Ports:
clk_16ms  in  1  system tick clock (16 ms period)
rst  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle
sample_in  in  W  raw sensor sample, unsigned
cal_req  in  1  one-cycle strobe; discard window and recapture reference
sen  out  W  filtered sample (window average), to FSM sen
sen_ref  out  W  captured baseline, to FSM sen_ref
ref_valid  out  1  sen_ref holds a valid baseline
enable_out  out  1  FSM enable; high only in RUN
stale  out  1  sample stream stalled

Behaviour:
- Reset: one clock, synchronous, active-high; rst is sampled on the clk_16ms edge only. It wins over all other inputs.
- Reset values: sen=0, sen_ref=0, ref_valid=0, enable_out=0, stale=0; state=FILL; fill_cnt=0, sum=0, wp=0, stale_cnt=0. Buffer contents need not be cleared.
- Window: circular buffer of D entries, write pointer wp (AVG_LOG2 bits, wraps D-1 to 0), running sum of W+AVG_LOG2 bits (cannot overflow).
- Accepted sample: sum_next = sum + sample_in - old, where old = buf[wp] if fill_cnt == D, else 0. Then buf[wp] <= sample_in, wp++, and fill_cnt increments, saturating at D.
- Average = sum_next >> AVG_LOG2, floor/truncation, no rounding.
- States:
  - FILL: accept samples. sen holds its last value; enable_out=0, ref_valid=0. On the edge accepting the D-th sample: sen <= avg, sen_ref <= avg, ref_valid <= 1, stale_cnt <= 0, go to RUN.
  - RUN: enable_out=1. Each accepted sample updates sen <= avg on the same edge (1-cycle latency from the sample_valid cycle). sen_ref is frozen. stale_cnt increments on each cycle without sample_valid and clears on sample_valid. When stale_cnt reaches STALE_TICKS: go to STALE, stale <= 1.
  - STALE: enable_out=0, stale=1, sen and sen_ref held. The next sample_valid is accepted normally (sen updates), then stale <= 0, stale_cnt <= 0, go to RUN.
- cal_req in any state:
  - fill_cnt <= 0, sum <= 0, wp <= 0, ref_valid <= 0, stale <= 0, go to FILL.
  - sen and sen_ref keep their old values.
  - cal_req in FILL restarts the fill.
- cal_req and sample_valid in the same cycle: cal_req wins and the sample is dropped.
- enable_out is a registered decode of state == RUN.
- sample_valid while rst is high: ignored.

Decomposition:
- Shared package (sensor_pkg): state encodings FILL/RUN/STALE (2-bit), default W, AVG_LOG2, STALE_TICKS. The FSM channel stage uses the same defaults.
- Sub-module sample_window: circular buffer, wp, fill_cnt and running sum. Interface: push, flush, din; outputs avg_next, full_next.
- Top level holds the state machine, stale counter and output registers.

Test Plan:
1. Reset, then 8 samples of 100 spaced 3 cycles apart: enable_out=0 and ref_valid=0 until the 8th accept edge; then sen=100, sen_ref=100, ref_valid=1, enable_out=1.
2. From test 1, 8 samples of 200: sen steps 112,125,137,150,162,175,187,200 (one per accept edge); sen_ref stays 100; enable_out stays 1.
3. Reset, 8 samples of 4095: sen=4095, sen_ref=4095, with no wrap or overflow. Then 1 sample of 0: sen=3583.
4. In RUN, withhold sample_valid for 63 cycles: stale=1 and enable_out=0 after the 63rd cycle; sen held. Next sample of 100: stale=0, enable_out=1 on that edge.
5. In RUN, assert cal_req together with sample_valid=1, sample_in=999: sample dropped, ref_valid=0, enable_out=0, sen unchanged. Then 8 samples of 50: sen_ref=50, ref_valid=1.
6. After 5 of 8 fill samples, assert rst for 1 cycle: all outputs 0. Only 8 further samples give ref_valid=1; 7 do not.
